// File: rtl/pcm_pkg.sv
// Shared types and sizing for the PCM playback fetch path.
// Holds the fetch FSM encoding, default buffer geometry and the half base-address helper.
package pcm_pkg;

    localparam int unsigned PCM_DATA_W     = 16;
    localparam int unsigned PCM_ADDR_W     = 10;
    localparam int unsigned PCM_HALF_PAIRS = 256;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        RD_L  = 3'd1,
        RD_R  = 3'd2,
        CAP_R = 3'd3,
        HOLD  = 3'd4
    } pcm_state_e;

    // Each half holds interleaved L/R words, so it spans 2*half_pairs addresses.
    function automatic int unsigned pcm_base(input logic half, input int unsigned half_pairs);
        return half ? 32'(2 * half_pairs) : 32'd0;
    endfunction

endpackage

// File: rtl/pcm_fetch.sv
// Ping-pong reader from the PCM sample buffer to the AC97 frame generator.
// Optional PCM_FETCH_SILENCE_EN: serve zero samples combinationally while starved.
//
// state | meaning
// WAIT  | idle until the current half is marked ready
// RD_L  | left word address presented to the buffer
// RD_R  | right word address presented, left word captured
// CAP_R | right word captured, pair made valid
// HOLD  | pair held until the consumer accepts it
module pcm_fetch
    import pcm_pkg::*;
#(
    parameter int unsigned DATA_W     = PCM_DATA_W,
    parameter int unsigned ADDR_W     = PCM_ADDR_W,
    parameter int unsigned HALF_PAIRS = PCM_HALF_PAIRS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        HALF_RDY,
    output logic [1:0]        HALF_DONE,
    output logic [ADDR_W-1:0] ADDRB,
    output logic              ENB,
    input  logic [DATA_W-1:0] DOB,
    output logic [DATA_W-1:0] PCM_L,
    output logic [DATA_W-1:0] PCM_R,
    output logic              PCM_VLD,
    input  logic              PCM_RDY,
    output logic              UNDERRUN
);

    localparam int unsigned CNT_W = $clog2(HALF_PAIRS);

    pcm_state_e        state_q;
    logic              cur_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addrb_q;
    logic              enb_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] pcm_l_q;
    logic [DATA_W-1:0] pcm_r_q;
    logic              vld_q;
    logic [1:0]        done_q;
    logic              underrun_q;

    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] addr_cur_d;
    logic [ADDR_W-1:0] addr_next_d;
    logic              last_pair;

    assign cnt_d       = cnt_q + CNT_W'(1);
    assign base_d      = ADDR_W'(pcm_base(cur_q, HALF_PAIRS));
    assign addr_cur_d  = base_d + ADDR_W'({cnt_q, 1'b0});
    assign addr_next_d = base_d + ADDR_W'({cnt_d, 1'b0});
    assign last_pair   = (cnt_q == CNT_W'(HALF_PAIRS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= WAIT;
            cur_q      <= 1'b0;
            cnt_q      <= '0;
            addrb_q    <= '0;
            enb_q      <= 1'b0;
            left_q     <= '0;
            pcm_l_q    <= '0;
            pcm_r_q    <= '0;
            vld_q      <= 1'b0;
            done_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= '0;
            underrun_q <= 1'b0;
            case (state_q)
                WAIT: begin
                    underrun_q <= PCM_RDY;
                    if (HALF_RDY[cur_q]) begin
                        addrb_q <= addr_cur_d;
                        enb_q   <= 1'b1;
                        state_q <= RD_L;
                    end
                end
                RD_L: begin
                    addrb_q <= addrb_q + ADDR_W'(1);
                    state_q <= RD_R;
                end
                // DOB now carries the left word addressed during RD_L.
                RD_R: begin
                    enb_q   <= 1'b0;
                    left_q  <= DOB;
                    state_q <= CAP_R;
                end
                CAP_R: begin
                    pcm_r_q <= DOB;
                    pcm_l_q <= left_q;
                    vld_q   <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (PCM_RDY) begin
                        vld_q <= 1'b0;
                        if (last_pair) begin
                            done_q[cur_q] <= 1'b1;
                            cnt_q         <= '0;
                            cur_q         <= ~cur_q;
                            state_q       <= WAIT;
                        end else begin
                            cnt_q   <= cnt_d;
                            addrb_q <= addr_next_d;
                            enb_q   <= 1'b1;
                            state_q <= RD_L;
                        end
                    end
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign HALF_DONE = done_q;
    assign ADDRB     = addrb_q;
    assign ENB       = enb_q;
    assign UNDERRUN  = underrun_q;

`ifdef PCM_FETCH_SILENCE_EN
    // A starved request is answered in the same cycle with a silent pair.
    logic silence;
    assign silence = (state_q == WAIT) && PCM_RDY;
    assign PCM_VLD = vld_q | silence;
    assign PCM_L   = silence ? '0 : pcm_l_q;
    assign PCM_R   = silence ? '0 : pcm_r_q;
`else
    assign PCM_VLD = vld_q;
    assign PCM_L   = pcm_l_q;
    assign PCM_R   = pcm_r_q;
`endif

endmodule

// File: tb/tb_pcm_fetch.sv
// Directed bench for pcm_fetch with a behavioural model of the 1024x16 sample buffer.
// Covers pair ordering, half hand-back, wrap, underrun, stall hold and mid-fetch reset.
module tb_pcm_fetch;
    import pcm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  half_rdy;
    logic [1:0]  half_done;
    logic [9:0]  addrb;
    logic        enb;
    logic [15:0] dob;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;
    logic        pcm_vld;
    logic        pcm_rdy;
    logic        underrun;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef PCM_FETCH_SILENCE_EN
    localparam logic EXP_STARVED_VLD = 1'b1;
`else
    localparam logic EXP_STARVED_VLD = 1'b0;
`endif

    always #5 clk = ~clk;

    pcm_fetch dut (
        .CLK      (clk),
        .RST      (rst),
        .HALF_RDY (half_rdy),
        .HALF_DONE(half_done),
        .ADDRB    (addrb),
        .ENB      (enb),
        .DOB      (dob),
        .PCM_L    (pcm_l),
        .PCM_R    (pcm_r),
        .PCM_VLD  (pcm_vld),
        .PCM_RDY  (pcm_rdy),
        .UNDERRUN (underrun)
    );

    logic [15:0] mem [0:1023];
    always @(posedge clk) dob <= enb ? mem[addrb] : 16'h0000;

    logic [9:0] addr_log [$];
    int n_done0 = 0;
    int n_done1 = 0;
    int n_under = 0;
    always @(posedge clk) begin
        if (enb) addr_log.push_back(addrb);
        if (half_done[0]) n_done0 <= n_done0 + 1;
        if (half_done[1]) n_done1 <= n_done1 + 1;
        if (underrun)     n_under <= n_under + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic wait_vld(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (pcm_vld) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic take_pair(output logic [15:0] l, output logic [15:0] r, output int lat);
        wait_vld(lat);
        l = pcm_l;
        r = pcm_r;
        pcm_rdy = 1'b1;
        @(posedge clk); #1;
        pcm_rdy = 1'b0;
    endtask

    function automatic bit pair_ok(int h, int p, logic [15:0] l, logic [15:0] r, int lat);
        int a;
        a = h * 2 * PCM_HALF_PAIRS + 2 * p;
        return (lat > 0) && (l === mem[a]) && (r === mem[a + 1]);
    endfunction

    initial begin
        logic [15:0] l, r;
        int lat, bad, u0, p, cyc;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h5000 | 16'(i);
        mem[0] = 16'h0001;
        mem[1] = 16'hFFFF;
        mem[2] = 16'h1234;
        mem[3] = 16'h8000;

        rst = 1'b1; half_rdy = 2'b00; pcm_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_half_done", half_done, 2'b00);
        check("rst_addrb", addrb, 0);
        check("rst_enb", enb, 0);
        check("rst_pcm_l", pcm_l, 0);
        check("rst_pcm_r", pcm_r, 0);
        check("rst_vld", pcm_vld, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;

        // Starved consumer: five requests, nothing ready.
        u0 = n_under; bad = 0;
        for (int i = 0; i < 5; i++) begin
            pcm_rdy = 1'b1;
            #1;
            if (pcm_vld !== EXP_STARVED_VLD || pcm_l !== 16'h0 || pcm_r !== 16'h0) bad++;
            @(posedge clk); #1;
        end
        pcm_rdy = 1'b0;
        @(posedge clk); #1;
        check("starved_outputs", bad, 0);
        check("underrun_pulses", n_under - u0, 5);
        check("underrun_idle", underrun, 0);
        check("starved_no_read", addr_log.size(), 0);

        // First two pairs of half 0.
        half_rdy = 2'b01;
        take_pair(l, r, lat);
        check("p0_l", l, 16'h0001);
        check("p0_r", r, 16'hFFFF);
        check("p0_latency", lat, 4);
        check("p0_vld_drop", pcm_vld, 0);
        take_pair(l, r, lat);
        check("p1_l", l, 16'h1234);
        check("p1_r", r, 16'h8000);
        check("p1_latency", lat, 3);
        check("addr_cnt", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) check("addr_seq", addr_log[i], i);

        // Consumer stalls 20 cycles on pair 2.
        wait_vld(lat);
        check("p2_latency", lat, 3);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pcm_l !== mem[4] || pcm_r !== mem[5] || pcm_vld !== 1'b1 || enb !== 1'b0) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_no_read", addr_log.size(), 6);
        pcm_rdy = 1'b1;
        @(posedge clk); #1;
        pcm_rdy = 1'b0;

        // Rest of half 0; its ready bit drops midway and half 1 is offered early.
        bad = 0;
        for (int i = 3; i < 256; i++) begin
            if (i == 128) half_rdy = 2'b10;
            take_pair(l, r, lat);
            if (!pair_ok(0, i, l, r, lat)) bad++;
            if (i < 255 && half_done !== 2'b00) bad++;
        end
        check("half0_data", bad, 0);
        check("half0_done", half_done, 2'b01);
        addr_log.delete();
        @(posedge clk); #1;
        check("half0_done_pulse", half_done, 2'b00);
        check("half1_first_addr", addrb, 512);
        check("half1_first_enb", enb, 1);

        // Half 1 streamed with PCM_RDY held high throughout the fetches.
        u0 = n_under; pcm_rdy = 1'b1; p = 0; bad = 0; cyc = 0;
        while (p < 256 && cyc < 2000) begin
            if (pcm_vld) begin
                if (pcm_l !== mem[512 + 2 * p] || pcm_r !== mem[513 + 2 * p]) bad++;
                p++;
            end
            @(posedge clk); #1;
            cyc++;
            if (p == 256) pcm_rdy = 1'b0;
        end
        pcm_rdy = 1'b0;
        check("half1_data", bad, 0);
        check("half1_pairs", p, 256);
        check("half1_cycles", cyc, 1024);
        check("half1_done", half_done, 2'b10);
        check("rdy_in_fetch_no_underrun", n_under - u0, 0);
        half_rdy = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("wait_no_read", addr_log.size(), 512);
        check("half1_last_addr", addr_log[511], 1023);

        // Wrap back to half 0.
        addr_log.delete();
        half_rdy = 2'b01;
        take_pair(l, r, lat);
        check("wrap_addr", addr_log[0], 0);
        check("wrap_l", l, 16'h0001);
        check("wrap_r", r, 16'hFFFF);
        check("wrap_latency", lat, 4);

        // Reset during RD_R of pair 100.
        bad = 0;
        for (int i = 1; i < 100; i++) begin
            take_pair(l, r, lat);
            if (!pair_ok(0, i, l, r, lat)) bad++;
        end
        check("pairs_to_100", bad, 0);
        @(posedge clk); #1;
        check("rd_r_addr", addrb, 201);
        check("rd_r_enb", enb, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_half_done", half_done, 2'b00);
        check("mid_rst_addrb", addrb, 0);
        check("mid_rst_enb", enb, 0);
        check("mid_rst_pcm_l", pcm_l, 0);
        check("mid_rst_pcm_r", pcm_r, 0);
        check("mid_rst_vld", pcm_vld, 0);
        check("mid_rst_underrun", underrun, 0);
        rst = 1'b0;
        addr_log.delete();
        take_pair(l, r, lat);
        check("restart_addr", addr_log[0], 0);
        check("restart_l", l, 16'h0001);
        check("restart_r", r, 16'hFFFF);
        @(posedge clk); #1;
        check("done0_total", n_done0, 1);
        check("done1_total", n_done1, 1);
        check("underrun_total", n_under, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pcm_fetch.md
Name: pcm_fetch

Overview:
- Playback-side reader between the 1024x16 PCM dual-port sample buffer (read port B) and the AC97 frame generator.
- Walks the buffer as two ping-pong halves, reading interleaved stereo words (even address = left, odd address = right).
- Presents each left/right pair on a valid/ready interface and returns each half to the MAC writer once all its pairs are consumed.

Parameters:
- DATA_W, 16, sample width; matches buffer data width.
- ADDR_W, 10, buffer address width.
- HALF_PAIRS, 256, stereo pairs per half. Half h spans word addresses h*2*HALF_PAIRS .. (h+1)*2*HALF_PAIRS-1. 2*2*HALF_PAIRS must not exceed 2^ADDR_W.

Ports:
- CLK  in  1  single clock. Also drives the buffer's port-B clock.
- RST  in  1  synchronous, active-high reset.
- HALF_RDY  in  2  level per half from the MAC writer: half h holds fresh samples. The writer clears bit h only after seeing HALF_DONE[h].
- HALF_DONE  out  2  one-cycle pulse: half h fully consumed.
- ADDRB  out  ADDR_W  buffer read address. The buffer registers it on CLK.
- ENB  out  1  buffer read enable. DOB is forced to 0 while ENB is low.
- DOB  in  DATA_W  buffer read data. Valid the cycle after ADDRB is sampled with ENB=1.
- PCM_L  out  DATA_W  left sample.
- PCM_R  out  DATA_W  right sample.
- PCM_VLD  out  1  pair valid.
- PCM_RDY  in  1  consumer (AC97 frame generator) accepts the pair.
- UNDERRUN  out  1  one-cycle pulse: consumer requested data but none was available.

Behaviour:
- Reset values: HALF_DONE=0, ADDRB=0, ENB=0, PCM_L=0, PCM_R=0, PCM_VLD=0, UNDERRUN=0. Internal state: half pointer cur=0, pair counter=0, FSM=WAIT.
- RST takes effect in any state, including mid-fetch or while PCM_VLD=1. The held pair is discarded and no HALF_DONE is issued.
- FSM states:
  - WAIT: idle until HALF_RDY[cur]=1, then go to RD_L.
  - RD_L: drive ADDRB = base(cur) + 2*cnt with ENB=1. Go to RD_R.
  - RD_R: drive ADDRB+1 with ENB=1; capture DOB into the left holding register. Go to CAP_R.
  - CAP_R: ENB=0; capture DOB into PCM_R and move left holding into PCM_L; set PCM_VLD=1. Go to HOLD.
  - HOLD: PCM_L, PCM_R and PCM_VLD stay stable until PCM_RDY=1. On handshake:
    - If cnt < HALF_PAIRS-1: cnt+1, go to RD_L.
    - Else: pulse HALF_DONE[cur], cnt=0, cur toggles, go to WAIT.
- PCM_VLD drops the cycle after a handshake. Fetch latency is 3 cycles from entering RD_L to PCM_VLD=1; minimum pair period is 4 cycles.
- Address wraps naturally: half 1 is followed by half 0. cnt is $clog2(HALF_PAIRS) bits wide.
- UNDERRUN pulses for every cycle in WAIT with PCM_RDY=1. PCM_RDY during RD_L, RD_R or CAP_R is ignored and is not an underrun.
- HALF_RDY[cur] deasserting mid-half is ignored; the half is always consumed completely.
- HALF_RDY of the non-current half has no effect until cur points to it.
- DOB data is treated as two's-complement but passed through unmodified.

Optional Feature:
- Macro: PCM_FETCH_SILENCE_EN.
- Defined: in WAIT with PCM_RDY=1, the block presents PCM_L=PCM_R=0 with PCM_VLD=1 in that same cycle, combinationally, so the consumer receives silence. UNDERRUN still pulses; cnt and cur are unchanged.
- Undefined: PCM_VLD stays 0 in WAIT and only UNDERRUN pulses.

Decomposition:
- Shared package pcm_pkg holds:
  - FSM state enum (WAIT, RD_L, RD_R, CAP_R, HOLD);
  - PCM_DATA_W=16, PCM_ADDR_W=10, PCM_HALF_PAIRS=256;
  - a function computing base(half).
- No sub-module; one FSM with counters. The bench instantiates this block together with the existing sample-buffer RAM.

Test Plan:
- Reset then HALF_RDY=2'b01, buffer words 0..3 = 16'h0001, 16'hFFFF, 16'h1234, 16'h8000, PCM_RDY=1 → first pair L=0001/R=FFFF; second pair L=1234/R=8000. ADDRB sequence is 0,1,2,3.
- Consume all 256 pairs of half 0 → HALF_DONE=2'b01 for exactly one cycle after the 256th handshake. With HALF_RDY[1]=1, the next ADDRB is 512.
- Consume half 1 fully → HALF_DONE=2'b10. The next fetch waits for HALF_RDY[0] and then reads address 0 (wrap).
- HALF_RDY=0, PCM_RDY=1 for 5 cycles → 5 UNDERRUN pulses. PCM_VLD stays 0, or with PCM_FETCH_SILENCE_EN: PCM_VLD=1 with L=R=0 in each cycle.
- Hold PCM_RDY=0 for 20 cycles while PCM_VLD=1 → PCM_L/PCM_R stable, ENB=0, no extra reads.
- Assert RST in RD_R of pair 100 → all outputs at reset values the next cycle. After release, fetching restarts at address 0 with no HALF_DONE.
